// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: 640x480@60 VGA timing generator with a two-stage
// colour/sync pipeline and a frame-boundary note latch.
// Optional build macro VGA_TEST_PATTERN_EN adds the test_en input, which
// replaces the renderer colour with eight 80-pixel vertical colour bars.
module vga_timing_ctrl #(
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BACK   = 48,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FRONT  = 16,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BACK   = 33,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FRONT  = 10
) (
    input  logic        vga_clk,
    input  logic        rst_n,
`ifdef VGA_TEST_PATTERN_EN
    input  logic        test_en,
`endif
    input  logic [7:0]  note_in,
    input  logic [23:0] pos_data,
    output logic [9:0]  pos_x,
    output logic [9:0]  pos_y,
    output logic [7:0]  note_frame,
    output logic        frame_start,
    output logic        hsync,
    output logic        vsync,
    output logic [23:0] rgb
);

    localparam int unsigned CNT_W   = 10;
    localparam int unsigned RGB_W   = 24;
    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_LO = CNT_W'(H_SYNC + H_BACK);
    localparam logic [CNT_W-1:0] H_ACT_HI = CNT_W'(H_SYNC + H_BACK + H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_ACT_LO = CNT_W'(V_SYNC + V_BACK);
    localparam logic [CNT_W-1:0] V_ACT_HI = CNT_W'(V_SYNC + V_BACK + V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] H_SYNC_N = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_N = CNT_W'(V_SYNC);

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic             eof_c;
    logic             act_c, hs0_c, vs0_c;
    logic             act1_q, hs1_q, vs1_q;
    logic             hsync_q, vsync_q;
    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic [7:0]       note_frame_q;
    logic             frame_start_q;

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] bar0_c, bar1_q;

    // Colour of each 80-pixel test bar, left to right
    function automatic logic [RGB_W-1:0] bar_rgb(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_rgb = 24'hFFFFFF;
            3'd1:    bar_rgb = 24'hFFFF00;
            3'd2:    bar_rgb = 24'h00FFFF;
            3'd3:    bar_rgb = 24'h00FF00;
            3'd4:    bar_rgb = 24'hFF00FF;
            3'd5:    bar_rgb = 24'hFF0000;
            3'd6:    bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase
    endfunction
`endif

    // Raster counter advance; vertical steps only on the last pixel of a line
    always_comb begin
        h_cnt_d = h_cnt_q + CNT_W'(1);
        v_cnt_d = v_cnt_q;
        eof_c   = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CNT_W'(1);
        end
    end

    // Stage 0: active window, renderer coordinates and raw sync levels
    always_comb begin
        act_c = (h_cnt_q >= H_ACT_LO) && (h_cnt_q <= H_ACT_HI) &&
                (v_cnt_q >= V_ACT_LO) && (v_cnt_q <= V_ACT_HI);
        pos_x = act_c ? (h_cnt_q - H_ACT_LO) : '0;
        pos_y = act_c ? (v_cnt_q - V_ACT_LO) : '0;
        hs0_c = (h_cnt_q >= H_SYNC_N);
        vs0_c = (v_cnt_q >= V_SYNC_N);
    end

`ifdef VGA_TEST_PATTERN_EN
    assign bar0_c = 3'(pos_x / CNT_W'(80));
`endif

    // Stage 2 colour select: blanking forces black
    always_comb begin
        rgb_d = '0;
        if (act1_q) begin
`ifdef VGA_TEST_PATTERN_EN
            rgb_d = test_en ? bar_rgb(bar1_q) : pos_data;
`else
            rgb_d = pos_data;
`endif
        end
    end

    // Raster counters
    always_ff @(posedge vga_clk) begin
        if (!rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Two-stage pipeline keeping sync and colour aligned with BRAM latency
    always_ff @(posedge vga_clk) begin
        if (!rst_n) begin
            act1_q  <= 1'b0;
            hs1_q   <= 1'b1;
            vs1_q   <= 1'b1;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            rgb_q   <= '0;
        end else begin
            act1_q  <= act_c;
            hs1_q   <= hs0_c;
            vs1_q   <= vs0_c;
            hsync_q <= hs1_q;
            vsync_q <= vs1_q;
            rgb_q   <= rgb_d;
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    // Bar index travels alongside act through stage 1
    always_ff @(posedge vga_clk) begin
        if (!rst_n) begin
            bar1_q <= '0;
        end else begin
            bar1_q <= bar0_c;
        end
    end
`endif

    // Frame-boundary note latch and frame start pulse
    always_ff @(posedge vga_clk) begin
        if (!rst_n) begin
            note_frame_q  <= '0;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= eof_c;
            if (eof_c) begin
                note_frame_q <= note_in;
            end
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign rgb         = rgb_q;
    assign note_frame  = note_frame_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Testbench for vga_timing_ctrl using reduced raster dimensions so several
// complete frames fit in a short run. Expected values come from a model that
// derives raster position directly from the cycle count since reset.
`timescale 1ns/1ps
module tb_vga_timing_ctrl;

    localparam int unsigned HS = 12, HB = 8, HA = 200, HF = 4;
    localparam int unsigned VS = 2,  VB = 3, VA = 6,   VF = 2;
    localparam int unsigned HT = HS + HB + HA + HF;
    localparam int unsigned VT = VS + VB + VA + VF;
    localparam int unsigned FRAME = HT * VT;

    logic        vga_clk;
    logic        rst_n;
    logic [7:0]  note_in;
    logic [23:0] pos_data;
    logic [9:0]  pos_x, pos_y;
    logic [7:0]  note_frame;
    logic        frame_start, hsync, vsync;
    logic [23:0] rgb;
`ifdef VGA_TEST_PATTERN_EN
    logic        test_en;
`endif

    int unsigned checks = 0;
    int unsigned passes = 0;
    int unsigned k = 0;
    logic [7:0]  exp_note = 8'h00;
    logic [23:0] exp_rgb  = 24'h0;
    logic [23:0] palette [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    vga_timing_ctrl #(
        .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF)
    ) dut (
        .vga_clk     (vga_clk),
        .rst_n       (rst_n),
`ifdef VGA_TEST_PATTERN_EN
        .test_en     (test_en),
`endif
        .note_in     (note_in),
        .pos_data    (pos_data),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .note_frame  (note_frame),
        .frame_start (frame_start),
        .hsync       (hsync),
        .vsync       (vsync),
        .rgb         (rgb)
    );

    initial vga_clk = 1'b0;
    always #20 vga_clk = ~vga_clk;

    // Reference model: raster position as a function of cycles since reset
    function automatic int unsigned h_of(input int unsigned kk);
        return kk % HT;
    endfunction
    function automatic int unsigned v_of(input int unsigned kk);
        return (kk / HT) % VT;
    endfunction
    function automatic bit act_of(input int unsigned kk);
        return (h_of(kk) >= HS + HB) && (h_of(kk) < HS + HB + HA) &&
               (v_of(kk) >= VS + VB) && (v_of(kk) < VS + VB + VA);
    endfunction
    function automatic int unsigned px_of(input int unsigned kk);
        return act_of(kk) ? h_of(kk) - (HS + HB) : 0;
    endfunction
    function automatic int unsigned py_of(input int unsigned kk);
        return act_of(kk) ? v_of(kk) - (VS + VB) : 0;
    endfunction
    function automatic logic exp_hs(input int unsigned kk);
        return (kk < 2) ? 1'b1 : logic'(h_of(kk - 2) >= HS);
    endfunction
    function automatic logic exp_vs(input int unsigned kk);
        return (kk < 2) ? 1'b1 : logic'(v_of(kk - 2) >= VS);
    endfunction
    function automatic logic exp_fs(input int unsigned kk);
        return logic'((kk > 0) && (kk % FRAME == 0));
    endfunction

    // Advance one clock, update the model from inputs seen at the edge,
    // present a fresh random renderer colour, and return at the falling edge
    task automatic tick();
        int unsigned k_old;
        @(posedge vga_clk);
        k_old = k;
        if (!rst_n) begin
            k        = 0;
            exp_note = 8'h00;
            exp_rgb  = 24'h0;
        end else begin
            if (k_old % FRAME == FRAME - 1) exp_note = note_in;
            exp_rgb = 24'h0;
            if (k_old >= 1 && act_of(k_old - 1)) begin
                exp_rgb = pos_data;
`ifdef VGA_TEST_PATTERN_EN
                if (test_en) exp_rgb = palette[px_of(k_old - 1) / 80];
`endif
            end
            k = k_old + 1;
        end
        #1 pos_data = 24'($urandom);
        @(negedge vga_clk);
    endtask

    task automatic run_to(input int unsigned h, input int unsigned v);
        for (int i = 0; i < int'(FRAME) + 1; i++) begin
            if (h_of(k) == h && v_of(k) == v) break;
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (pos_x !== 10'd0)       $display("FAIL reset_pos_x got %0d exp 0", pos_x); else passes++;
        checks++; if (pos_y !== 10'd0)       $display("FAIL reset_pos_y got %0d exp 0", pos_y); else passes++;
        checks++; if (hsync !== 1'b1)        $display("FAIL reset_hsync got %b exp 1", hsync); else passes++;
        checks++; if (vsync !== 1'b1)        $display("FAIL reset_vsync got %b exp 1", vsync); else passes++;
        checks++; if (rgb !== 24'h0)         $display("FAIL reset_rgb got %h exp 0", rgb); else passes++;
        checks++; if (note_frame !== 8'h00)  $display("FAIL reset_note got %h exp 00", note_frame); else passes++;
        checks++; if (frame_start !== 1'b0)  $display("FAIL reset_fs got %b exp 0", frame_start); else passes++;
        rst_n = 1'b1;
    endtask

    task automatic test_timing();
        int unsigned hs_low = 0, vs_low = 0, fs_cnt = 0;
        for (int n = 0; n < int'(2 * FRAME) + 4; n++) begin
            if ($urandom_range(0, 63) == 0) note_in = 8'($urandom);
            tick();
            checks++; if (pos_x !== 10'(px_of(k))) $display("FAIL pos_x k=%0d got %0d exp %0d", k, pos_x, px_of(k)); else passes++;
            checks++; if (pos_y !== 10'(py_of(k))) $display("FAIL pos_y k=%0d got %0d exp %0d", k, pos_y, py_of(k)); else passes++;
            checks++; if (hsync !== exp_hs(k))     $display("FAIL hsync k=%0d got %b exp %b", k, hsync, exp_hs(k)); else passes++;
            checks++; if (vsync !== exp_vs(k))     $display("FAIL vsync k=%0d got %b exp %b", k, vsync, exp_vs(k)); else passes++;
            checks++; if (rgb !== exp_rgb)         $display("FAIL rgb k=%0d got %h exp %h", k, rgb, exp_rgb); else passes++;
            checks++; if (frame_start !== exp_fs(k)) $display("FAIL frame_start k=%0d got %b exp %b", k, frame_start, exp_fs(k)); else passes++;
            checks++; if (note_frame !== exp_note) $display("FAIL note_frame k=%0d got %h exp %h", k, note_frame, exp_note); else passes++;
            if (k >= FRAME && k < 2 * FRAME) begin
                hs_low += (hsync == 1'b0) ? 1 : 0;
                vs_low += (vsync == 1'b0) ? 1 : 0;
                fs_cnt += (frame_start == 1'b1) ? 1 : 0;
            end
        end
        checks++; if (hs_low != VT * HS) $display("FAIL hsync_low_count got %0d exp %0d", hs_low, VT * HS); else passes++;
        checks++; if (vs_low != VS * HT) $display("FAIL vsync_low_count got %0d exp %0d", vs_low, VS * HT); else passes++;
        checks++; if (fs_cnt != 1)       $display("FAIL frame_start_count got %0d exp 1", fs_cnt); else passes++;
    endtask

    task automatic test_boundaries();
        run_to(HS + HB, VS + VB);
        checks++; if (pos_x !== 10'd0) $display("FAIL first_px got %0d exp 0", pos_x); else passes++;
        checks++; if (pos_y !== 10'd0) $display("FAIL first_py got %0d exp 0", pos_y); else passes++;
        run_to(HS + HB + HA - 1, VS + VB + VA - 1);
        checks++; if (pos_x !== 10'(HA - 1)) $display("FAIL last_px got %0d exp %0d", pos_x, HA - 1); else passes++;
        checks++; if (pos_y !== 10'(VA - 1)) $display("FAIL last_py got %0d exp %0d", pos_y, VA - 1); else passes++;
        tick();
        checks++; if (pos_x !== 10'd0) $display("FAIL past_px got %0d exp 0", pos_x); else passes++;
        checks++; if (pos_y !== 10'd0) $display("FAIL past_py got %0d exp 0", pos_y); else passes++;
        tick();
        checks++; if (rgb !== exp_rgb) $display("FAIL last_rgb got %h exp %h", rgb, exp_rgb); else passes++;
        tick();
        checks++; if (rgb !== 24'h0) $display("FAIL blank_rgb got %h exp 0", rgb); else passes++;
    endtask

    task automatic test_note_latch();
        note_in = 8'h00;
        run_to(HT - 1, VT - 1);
        tick();
        checks++; if (note_frame !== 8'h00) $display("FAIL note_init got %h exp 00", note_frame); else passes++;
        run_to(0, 6);
        note_in = 8'h05;
        run_to(HT - 1, VT - 1);
        checks++; if (note_frame !== 8'h00) $display("FAIL note_hold got %h exp 00", note_frame); else passes++;
        tick();
        checks++; if (note_frame !== 8'h05) $display("FAIL note_latch got %h exp 05", note_frame); else passes++;
        run_to(50, 7);
        note_in = 8'h7F;
        tick();
        note_in = 8'h05;
        tick();
        checks++; if (note_frame !== 8'h05) $display("FAIL note_glitch_mid got %h exp 05", note_frame); else passes++;
        run_to(HT - 1, VT - 1);
        tick();
        checks++; if (note_frame !== 8'h05) $display("FAIL note_glitch_frame got %h exp 05", note_frame); else passes++;
        run_to(HT - 1, VT - 1);
        note_in = 8'h3C;
        tick();
        checks++; if (note_frame !== 8'h3C) $display("FAIL note_edge got %h exp 3c", note_frame); else passes++;
        note_in = 8'h00;
        for (int i = 0; i < 10; i++) tick();
        checks++; if (note_frame !== 8'h3C) $display("FAIL note_edge_hold got %h exp 3c", note_frame); else passes++;
        checks++; if (note_frame !== exp_note) $display("FAIL note_model got %h exp %h", note_frame, exp_note); else passes++;
    endtask

    task automatic test_reset_midframe();
        run_to(100, 7);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (hsync !== 1'b1 || vsync !== 1'b1) $display("FAIL mrst_c0_sync got %b%b exp 11", hsync, vsync); else passes++;
        checks++; if (rgb !== 24'h0) $display("FAIL mrst_c0_rgb got %h exp 0", rgb); else passes++;
        checks++; if (frame_start !== 1'b0) $display("FAIL mrst_c0_fs got %b exp 0", frame_start); else passes++;
        tick();
        checks++; if (hsync !== 1'b1 || vsync !== 1'b1) $display("FAIL mrst_c1_sync got %b%b exp 11", hsync, vsync); else passes++;
        checks++; if (rgb !== 24'h0) $display("FAIL mrst_c1_rgb got %h exp 0", rgb); else passes++;
        tick();
        checks++; if (hsync !== 1'b0) $display("FAIL mrst_c2_hsync got %b exp 0", hsync); else passes++;
        for (int n = 0; n < int'(HT * (VS + VB + 1)); n++) begin
            tick();
            checks++; if (hsync !== exp_hs(k) || rgb !== exp_rgb) $display("FAIL mrst_resume k=%0d got %b/%h exp %b/%h", k, hsync, rgb, exp_hs(k), exp_rgb); else passes++;
        end
        run_to(HT - 1, VT - 1);
        checks++; if (frame_start !== 1'b0) $display("FAIL fs_before got %b exp 0", frame_start); else passes++;
        tick();
        checks++; if (frame_start !== 1'b1) $display("FAIL fs_pulse got %b exp 1", frame_start); else passes++;
        tick();
        checks++; if (frame_start !== 1'b0) $display("FAIL fs_after got %b exp 0", frame_start); else passes++;
    endtask

`ifdef VGA_TEST_PATTERN_EN
    task automatic test_pattern();
        test_en = 1'b1;
        run_to(HS + HB, VS + VB);
        tick();
        tick();
        checks++; if (rgb !== 24'hFFFFFF) $display("FAIL bar0 got %h exp ffffff", rgb); else passes++;
        for (int n = 0; n < int'(FRAME); n++) begin
            tick();
            checks++; if (rgb !== exp_rgb) $display("FAIL pattern k=%0d got %h exp %h", k, rgb, exp_rgb); else passes++;
        end
        test_en = 1'b0;
    endtask
`endif

    initial begin
        rst_n    = 1'b0;
        note_in  = 8'h00;
        pos_data = 24'h0;
`ifdef VGA_TEST_PATTERN_EN
        test_en  = 1'b0;
`endif
        @(negedge vga_clk);
        test_reset();
        test_timing();
        test_boundaries();
        test_note_latch();
        test_reset_midframe();
`ifdef VGA_TEST_PATTERN_EN
        test_pattern();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
- Generates 640x480@60 Hz VGA timing from the 25 MHz pixel clock.
- Drives the pixel coordinates (pos_x/pos_y) that the note-sprite renderer consumes, and takes that renderer's 24-bit pixel colour back.
- Outputs pipeline-aligned hsync/vsync/rgb to the connector.
- Latches the live note vector once per frame, so sprites never change mid-frame.

Parameters:
- H_SYNC, 96, hsync pulse width in pixel clocks
- H_BACK, 48, horizontal back porch
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch
- V_SYNC, 2, vsync pulse width in lines
- V_BACK, 33, vertical back porch
- V_ACTIVE, 480, visible lines
- V_FRONT, 10, vertical front porch

Ports:
- vga_clk  in  1  pixel clock, 25 MHz
- rst_n  in  1  synchronous active-low reset
- note_in  in  8  live note vector from the keyboard/player; bit0=C … bit6=B, bit7 reserved
- pos_data  in  24  renderer colour for the previous cycle's pos_x/pos_y (1-cycle BRAM latency)
- pos_x  out  10  active-area column 0..639; 0 outside active
- pos_y  out  10  active-area row 0..479; 0 outside active
- note_frame  out  8  frame-stable note vector fed to the renderer
- frame_start  out  1  one-cycle pulse at h_cnt=0, v_cnt=0
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- rgb  out  24  pixel colour, 8:8:8 R:G:B

Behaviour:
- Clock and reset: all state is on the rising edge of vga_clk. Reset is synchronous active-low and wins over every other event.
- Derived totals: H_TOTAL = sum of the four H params (800); V_TOTAL = sum of the four V params (525).
- Horizontal counter: h_cnt counts 0..H_TOTAL-1 and wraps to 0.
- Vertical counter: v_cnt increments only when h_cnt = H_TOTAL-1, and wraps from V_TOTAL-1 to 0.
- Counter reset value: both counters reset to 0.
- Region layout: sync is first, then back porch, then active, then front porch.
  - h_act = (h_cnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_ACTIVE-1]), i.e. 144..783.
  - v_act is the analogous vertical window, 35..514.
  - act = h_act & v_act.
- Stage 0 (combinational from counters):
  - pos_x = act ? h_cnt-144 : 0; pos_y = act ? v_cnt-35 : 0.
  - Outside act, pos_x and pos_y are forced to 0 on both axes.
  - hs0 = (h_cnt < H_SYNC) ? 0 : 1; vs0 is the analogous vertical term.
- Stage 1 (registered): act1, hs1 and vs1 capture act, hs0 and vs0. pos_data is valid during this stage.
- Stage 2 (registered outputs):
  - rgb <= act1 ? pos_data : 24'h000000.
  - hsync <= hs1; vsync <= vs1.
  - Total latency from counter to pin is 2 cycles for sync and colour alike, so alignment is exact.
- Output reset values: hsync=1, vsync=1, rgb=0, act1=0, hs1=1, vs1=1, note_frame=0, frame_start=0.
- Note latch:
  - note_frame <= note_in on the single cycle where h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1 (end of frame). It holds otherwise.
  - note_in changes mid-frame have no effect until the next frame boundary.
  - A change on the exact latch cycle is captured.
- frame_start is registered: it is high during the cycle where the counters equal (0,0), and low otherwise.
- Reset mid-frame: counters go to 0 on the next edge and the pipeline flushes. The first two post-reset cycles emit rgb=0, hsync=1, vsync=1, then normal timing resumes from (0,0). No partial-line recovery is attempted.
- Width rules: all subtractions are unsigned 10-bit and are evaluated only inside act, so no underflow reaches the outputs.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- Defined:
  - Extra input port test_en (1 bit) is added.
  - When test_en=1, stage 2 replaces pos_data with 8 vertical colour bars, each 80 px wide. Bar index = pos_x[9:0]/80, carried through stage 1.
  - Bar colours in order: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - Blanking still forces 0, and sync timing is unchanged.
- Undefined: the port does not exist and rgb is always pos_data/blank as above.

Test Plan:
- Reset then run 800x525 cycles -> hsync low for exactly 96 clocks per line; vsync low for exactly 2x800 clocks per frame; frame_start pulses once every 420000 clocks.
- Counters at h_cnt=144, v_cnt=35 -> pos_x=0, pos_y=0. At h_cnt=783, v_cnt=514 -> pos_x=639, pos_y=479. At h_cnt=784 -> pos_x=0.
- Model pos_data = {pos_y[7:0], pos_x[7:0], 8'hA5} with 1-cycle delay -> rgb equals that value for the matching pixel exactly 2 cycles after the counter; rgb=0 throughout blanking.
- Change note_in 8'h00->8'h05 at line 200 -> note_frame stays 00 until the cycle after (799,524), then reads 05. Pulsing 8'h7F for one mid-frame cycle -> not captured.
- Assert rst_n=0 for 1 cycle at h_cnt=400, v_cnt=300 -> next cycle counters are (0,0). The following two output cycles give hsync=1, vsync=1, rgb=0, then hsync falls at the 3rd cycle.
- With VGA_TEST_PATTERN_EN and test_en=1 -> rgb=FFFFFF for pos_x 0..79, FFFF00 for 80..159, … 000000 for 560..639.
